// File: rtl/multi_screen_drawer_if.sv
// multi_screen_drawer_if: frame descriptor in, box command out, end-of-frame pulse
interface multi_screen_drawer_if #(
    parameter int NUM_OBJ = 3
);
    logic                   s_ready;
    logic                   s_valid;
    logic [NUM_OBJ-1:0]     in_obj_en;
    logic [9*NUM_OBJ-1:0]   in_x;
    logic [9*NUM_OBJ-1:0]   in_y;
    logic [9*NUM_OBJ-1:0]   in_w;
    logic [9*NUM_OBJ-1:0]   in_h;
    logic [3*NUM_OBJ-1:0]   in_color;
    logic                   m_ready;
    logic                   m_valid;
    logic [8:0]             out_box_x;
    logic [8:0]             out_box_y;
    logic [8:0]             out_box_w;
    logic [8:0]             out_box_h;
    logic [2:0]             out_box_color;
    logic                   frame_done;

    modport master (
        input  s_ready, m_valid, out_box_x, out_box_y, out_box_w, out_box_h, out_box_color, frame_done,
        output s_valid, in_obj_en, in_x, in_y, in_w, in_h, in_color, m_ready
    );

    modport slave (
        output s_ready, m_valid, out_box_x, out_box_y, out_box_w, out_box_h, out_box_color, frame_done,
        input  s_valid, in_obj_en, in_x, in_y, in_w, in_h, in_color, m_ready
    );
endinterface

// File: rtl/multi_screen_drawer.sv
// multi_screen_drawer: per frame, issue a background box then each enabled object box, then pace to the refresh period.
// Optional macro MULTI_SCREEN_DRAWER_CLIP_EN: skip off-screen objects and clip width/height to the screen edge.
module multi_screen_drawer #(
    parameter int          NUM_OBJ            = 3,
    parameter logic [8:0]  SCREEN_WIDTH       = 9'd320,
    parameter logic [8:0]  SCREEN_HEIGHT      = 9'd240,
    parameter logic [31:0] REFRESH_RATE_COUNT = 32'd833332,
    parameter logic [2:0]  BG_COLOR           = 3'd0
) (
    input logic clock,
    input logic reset,
    multi_screen_drawer_if.slave bus
);
    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BG, S_OBJ, S_REFRESH} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [NUM_OBJ-1:0]     en_q, en_d;
    logic [9*NUM_OBJ-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [3*NUM_OBJ-1:0]   c_q, c_d;

    logic [8:0] cur_x, cur_y, cur_w, cur_h, box_w, box_h;
    logic [2:0] cur_c;
    logic       vis;
    logic       last;

    assign cur_x = x_q[9*int'(idx_q) +: 9];
    assign cur_y = y_q[9*int'(idx_q) +: 9];
    assign cur_w = w_q[9*int'(idx_q) +: 9];
    assign cur_h = h_q[9*int'(idx_q) +: 9];
    assign cur_c = c_q[3*int'(idx_q) +: 3];
    assign last  = idx_q == IW'(NUM_OBJ - 1);

`ifdef MULTI_SCREEN_DRAWER_CLIP_EN
    logic [9:0] room_w, room_h;
    // Room left to the screen edge; only used when the object starts on-screen, so never wraps
    always_comb begin
        room_w = {1'b0, SCREEN_WIDTH} - {1'b0, cur_x};
        room_h = {1'b0, SCREEN_HEIGHT} - {1'b0, cur_y};
        vis    = en_q[idx_q] && (cur_x < SCREEN_WIDTH) && (cur_y < SCREEN_HEIGHT);
        box_w  = ({1'b0, cur_w} < room_w) ? cur_w : room_w[8:0];
        box_h  = ({1'b0, cur_h} < room_h) ? cur_h : room_h[8:0];
    end
`else
    // Fields pass through untouched; only the enable decides whether an object is drawn
    always_comb begin
        vis   = en_q[idx_q];
        box_w = cur_w;
        box_h = cur_h;
    end
`endif

    // Next-state, descriptor latch and saturating refresh counter
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        c_d     = c_q;
        cnt_d   = (state_q == S_BG) ? 32'd0 :
                  (cnt_q >= REFRESH_RATE_COUNT) ? REFRESH_RATE_COUNT : cnt_q + 32'd1;
        case (state_q)
            S_IDLE: if (bus.s_valid) begin
                en_d    = bus.in_obj_en;
                x_d     = bus.in_x;
                y_d     = bus.in_y;
                w_d     = bus.in_w;
                h_d     = bus.in_h;
                c_d     = bus.in_color;
                idx_d   = '0;
                state_d = S_BG;
            end
            S_BG: if (bus.m_ready) state_d = S_OBJ;
            S_OBJ: if (!vis || bus.m_ready) begin
                state_d = last ? S_REFRESH : S_OBJ;
                idx_d   = last ? idx_q : idx_q + 1'b1;
            end
            default: if (cnt_q == REFRESH_RATE_COUNT) state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any frame in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            c_q     <= c_d;
        end
    end

    // Outputs decode only registered state, so command fields hold steady while stalled
    always_comb begin
        bus.s_ready       = state_q == S_IDLE;
        bus.frame_done    = (state_q == S_REFRESH) && (cnt_q == REFRESH_RATE_COUNT);
        bus.m_valid       = (state_q == S_BG) || ((state_q == S_OBJ) && vis);
        bus.out_box_x     = 9'd0;
        bus.out_box_y     = 9'd0;
        bus.out_box_w     = 9'd1;
        bus.out_box_h     = 9'd1;
        bus.out_box_color = 3'd0;
        if (state_q == S_BG) begin
            bus.out_box_w     = SCREEN_WIDTH;
            bus.out_box_h     = SCREEN_HEIGHT;
            bus.out_box_color = BG_COLOR;
        end else if ((state_q == S_OBJ) && vis) begin
            bus.out_box_x     = cur_x;
            bus.out_box_y     = cur_y;
            bus.out_box_w     = box_w;
            bus.out_box_h     = box_h;
            bus.out_box_color = cur_c;
        end
    end
endmodule

// File: tb/tb_multi_screen_drawer.sv
// tb_multi_screen_drawer: scoreboard bench for multi_screen_drawer on a 16x12 screen with a 40-clock frame period
module tb_multi_screen_drawer;
    typedef struct {
        logic [8:0] x, y, w, h;
        logic [2:0] c;
        int         dly;
        bit         bg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bg_cyc = 0;
    exp_t sb[$];

    multi_screen_drawer_if #(.NUM_OBJ(3)) bus ();

    multi_screen_drawer #(
        .NUM_OBJ(3),
        .SCREEN_WIDTH(9'd16),
        .SCREEN_HEIGHT(9'd12),
        .REFRESH_RATE_COUNT(32'd40),
        .BG_COLOR(3'd0)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic push(input int x, input int y, input int w, input int h, input int c, input int dly);
        exp_t e;
        e.x = 9'(x); e.y = 9'(y); e.w = 9'(w); e.h = 9'(h); e.c = 3'(c); e.dly = dly; e.bg = 1'b0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] en, input logic [26:0] xs, input logic [26:0] ys,
                               input logic [26:0] ws, input logic [26:0] hs, input logic [8:0] cs);
        exp_t e;
        int   n = 0;
        e.x = 0; e.y = 0; e.w = 16; e.h = 12; e.c = 0; e.dly = 0; e.bg = 1'b1;
        sb.push_front(e);
        while (!bus.s_ready && n < 100) begin tick(); n++; end
        chk("s_ready_wait", 32'(bus.s_ready), 1);
        bus.s_valid = 1'b1; bus.in_obj_en = en;
        bus.in_x = xs; bus.in_y = ys; bus.in_w = ws; bus.in_h = hs; bus.in_color = cs;
        tick();
        bus.s_valid = 1'b0; bus.in_obj_en = ~en;
        bus.in_x = ~xs; bus.in_y = ~ys; bus.in_w = ~ws; bus.in_h = ~hs; bus.in_color = ~cs;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.m_valid && n < 100) begin tick(); n++; end
        chk("m_valid_wait", 32'(bus.m_valid), 1);
    endtask

    task automatic accept_one();
        wait_valid();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        while (!bus.frame_done && n < 200) begin tick(); n++; end
        chk("frame_done_wait", 32'(bus.frame_done), 1);
        tick();
        chk("idle_s_ready", 32'(bus.s_ready), 1);
        chk("idle_m_valid", 32'(bus.m_valid), 0);
        chk("idle_frame_done", 32'(bus.frame_done), 0);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    // Monitor: every accepted command is popped and compared; frame_done is timed from the BG accept
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", 32'(bus.out_box_x), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_x", 32'(bus.out_box_x), 32'(e.x));
                    chk("cmd_y", 32'(bus.out_box_y), 32'(e.y));
                    chk("cmd_w", 32'(bus.out_box_w), 32'(e.w));
                    chk("cmd_h", 32'(bus.out_box_h), 32'(e.h));
                    chk("cmd_color", 32'(bus.out_box_color), 32'(e.c));
                    if (e.bg) bg_cyc = cyc;
                    else if (e.dly >= 0) chk("cmd_slot", 32'(cyc - bg_cyc), 32'(e.dly));
                end
            end
            // Counter is cleared in the BG accept cycle and reaches 40 forty edges later
            if (bus.frame_done) chk("frame_done_latency", 32'(cyc - bg_cyc), 41);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 0; bus.in_obj_en = 0; bus.in_x = 0; bus.in_y = 0;
        bus.in_w = 0; bus.in_h = 0; bus.in_color = 0; bus.m_ready = 0;
        repeat (3) tick();
        chk("rst_s_ready", 32'(bus.s_ready), 1);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_w", 32'(bus.out_box_w), 1);
        chk("rst_h", 32'(bus.out_box_h), 1);
        rst = 1'b0;
        #1;
        chk("rel_s_ready", 32'(bus.s_ready), 1);
        chk("rel_m_valid", 32'(bus.m_valid), 0);

        // All three objects, back-to-back with m_ready held high
        bus.m_ready = 1'b1;
        push(1, 2, 3, 4, 1, 1); push(5, 6, 2, 2, 2, 2); push(10, 8, 6, 4, 7, 3);
        start_frame(3'b111, {9'd10, 9'd5, 9'd1}, {9'd8, 9'd6, 9'd2}, {9'd6, 9'd2, 9'd3},
                    {9'd4, 9'd2, 9'd4}, {3'd7, 3'd2, 3'd1});
        wait_fd();

        // Object 1 disabled: one idle slot between obj0 and obj2
        push(1, 2, 3, 4, 1, 1); push(10, 8, 6, 4, 7, 3);
        start_frame(3'b101, {9'd10, 9'd5, 9'd1}, {9'd8, 9'd6, 9'd2}, {9'd6, 9'd2, 9'd3},
                    {9'd4, 9'd2, 9'd4}, {3'd7, 3'd2, 3'd1});
        wait_fd();

        // Stall obj1 for five cycles
        bus.m_ready = 1'b0;
        push(1, 2, 3, 4, 1, -1); push(5, 6, 2, 2, 2, -1); push(10, 8, 6, 4, 7, -1);
        start_frame(3'b111, {9'd10, 9'd5, 9'd1}, {9'd8, 9'd6, 9'd2}, {9'd6, 9'd2, 9'd3},
                    {9'd4, 9'd2, 9'd4}, {3'd7, 3'd2, 3'd1});
        accept_one();
        accept_one();
        wait_valid();
        repeat (5) begin
            chk("stall_m_valid", 32'(bus.m_valid), 1);
            chk("stall_x", 32'(bus.out_box_x), 5);
            chk("stall_color", 32'(bus.out_box_color), 2);
            tick();
        end
        accept_one();
        accept_one();
        wait_fd();

        // Reset while obj1 is presented
        push(1, 2, 3, 4, 1, -1); push(5, 6, 2, 2, 2, -1); push(10, 8, 6, 4, 7, -1);
        start_frame(3'b111, {9'd10, 9'd5, 9'd1}, {9'd8, 9'd6, 9'd2}, {9'd6, 9'd2, 9'd3},
                    {9'd4, 9'd2, 9'd4}, {3'd7, 3'd2, 3'd1});
        accept_one();
        accept_one();
        wait_valid();
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 0);
        chk("midrst_s_ready", 32'(bus.s_ready), 1);
        chk("midrst_w", 32'(bus.out_box_w), 1);
        sb.delete();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("postrst_s_ready", 32'(bus.s_ready), 1);
        chk("postrst_m_valid", 32'(bus.m_valid), 0);

        // No objects: background only, then the refresh wait
        bus.m_ready = 1'b1;
        start_frame(3'b000, {9'd10, 9'd5, 9'd1}, {9'd8, 9'd6, 9'd2}, {9'd6, 9'd2, 9'd3},
                    {9'd4, 9'd2, 9'd4}, {3'd7, 3'd2, 3'd1});
        wait_fd();

        // Objects crossing or beyond the screen edge
`ifdef MULTI_SCREEN_DRAWER_CLIP_EN
        push(14, 0, 2, 3, 4, 1); push(3, 10, 4, 2, 3, 3);
`else
        push(14, 0, 4, 3, 4, 1); push(20, 1, 2, 2, 6, 2); push(3, 10, 4, 5, 3, 3);
`endif
        start_frame(3'b111, {9'd3, 9'd20, 9'd14}, {9'd10, 9'd1, 9'd0}, {9'd4, 9'd2, 9'd4},
                    {9'd5, 9'd2, 9'd3}, {3'd3, 3'd6, 3'd4});
        wait_fd();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_screen_drawer.md
MULTI_SCREEN_DRAWER -- requirements
Module: multi_screen_drawer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 3: number of boxes drawn per frame (1..16).
REQ-002 SHALL have parameter SCREEN_WIDTH, default 9'd320: screen width in pixels.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 9'd240: screen height in pixels.
REQ-004 SHALL have parameter REFRESH_RATE_COUNT, default 32'd833332: minimum frame period in clocks.
REQ-005 SHALL have parameter BG_COLOR, default 3'd0: background fill colour.
REQ-006 SHALL have port clock, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port s_ready, output, 1: ready to accept a new frame descriptor.
REQ-009 SHALL have port s_valid, input, 1: frame descriptor valid.
REQ-010 SHALL have port in_obj_en, input, NUM_OBJ: per-object draw enable.
REQ-011 SHALL have ports in_x, in_y, in_w and in_h, input, 9*NUM_OBJ each: packed per-object position and size, object i at bits [9i+8:9i].
REQ-012 SHALL have port in_color, input, 3*NUM_OBJ: packed per-object colour.
REQ-013 SHALL have port m_ready, input, 1: box drawer accepts the command.
REQ-014 SHALL have port m_valid, output, 1: box command valid.
REQ-015 SHALL have ports out_box_x, out_box_y, out_box_w and out_box_h, output, 9 each, plus out_box_color, output, 3: box command fields.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse at end of frame.

Function
REQ-017 SHALL implement the states S_IDLE, S_BG, S_OBJ and S_REFRESH.
REQ-018 S_IDLE SHALL hold s_ready=1 and m_valid=0; s_valid=1 SHALL latch all in_* fields, clear obj_idx to 0 and go to S_BG.
REQ-019 S_BG SHALL drive m_valid=1 with x=0, y=0, w=SCREEN_WIDTH, h=SCREEN_HEIGHT and color=BG_COLOR; m_ready=1 SHALL go to S_OBJ.
REQ-020 S_OBJ with latched en[obj_idx]=1 SHALL drive m_valid=1 with latched object obj_idx; m_ready=1 SHALL advance.
REQ-021 S_OBJ with en[obj_idx]=0 SHALL hold m_valid=0 for exactly one cycle and then advance.
REQ-022 Advance SHALL mean: if obj_idx==NUM_OBJ-1 go to S_REFRESH, else obj_idx+1.
REQ-023 Commands SHALL be issued in index order, one per m_valid&m_ready cycle, with command fields stable while m_valid=1 and m_ready=0.
REQ-024 refresh_count (32-bit) SHALL be cleared every cycle in S_BG, otherwise increment, saturating at REFRESH_RATE_COUNT.
REQ-025 S_REFRESH SHALL go to S_IDLE and pulse frame_done=1 when refresh_count==REFRESH_RATE_COUNT; if already saturated on entry, it SHALL exit on the next cycle.
REQ-026 Outside S_BG/S_OBJ the outputs SHALL be m_valid=0, x=0, y=0, w=1, h=1 and color=0.
REQ-027 in_* changes outside the S_IDLE accept cycle SHALL have no effect on the current frame.
REQ-028 An all-zero in_obj_en SHALL produce only the background command, then S_REFRESH.

Reset
REQ-029 reset=1 SHALL immediately force S_IDLE, obj_idx=0, refresh_count=0, latched fields=0 and frame_done=0, including mid-frame, with no further commands.
REQ-030 After reset release, s_ready SHALL be 1 and m_valid 0 in the same cycle.

Configuration
REQ-031 With macro MULTI_SCREEN_DRAWER_CLIP_EN defined, an enabled object with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT SHALL be skipped as in REQ-021.
REQ-032 With MULTI_SCREEN_DRAWER_CLIP_EN defined, out_box_w SHALL be min(w, SCREEN_WIDTH-x) and out_box_h min(h, SCREEN_HEIGHT-y), computed at 10 bits with no wrap.
REQ-033 Without MULTI_SCREEN_DRAWER_CLIP_EN, fields SHALL pass unmodified and no object is skipped for position.

Verification (NUM_OBJ=3, SCREEN 16x12, REFRESH_RATE_COUNT=40)
REQ-034 Enables 3'b111 with m_ready=1 -> commands BG(0,0,16,12,0), obj0, obj1, obj2 on 4 consecutive cycles; frame_done 40 cycles after BG accept.
REQ-035 Enables 3'b101 -> BG, obj0, one idle cycle, obj2; obj1 is never issued.
REQ-036 m_ready held 0 for 5 cycles during obj1 -> obj1 fields stable, m_valid=1 throughout, obj1 issued once.
REQ-037 reset pulsed during obj1 -> m_valid=0 immediately; s_ready=1 after release; the next frame starts with BG.
REQ-038 CLIP_EN with obj0 x=14, w=4 and obj1 x=20 -> obj0 issued with w=2; obj1 skipped. Without CLIP_EN -> w=4 and x=20 issued.
REQ-039 Enables 3'b000 -> BG only; frame_done pulse after 40 cycles; s_ready returns to 1.
